// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the dual-issue fetch queue.
package fetch_queue_pkg;

   localparam int          FQ_XLEN   = 32;
   localparam logic [31:0] NOP_INSTR = 32'h00000013;  // addi x0, x0, 0

   typedef struct packed {
      logic [FQ_XLEN-1:0] pc;
      logic [FQ_XLEN-1:0] instr;
   } fq_entry_t;

   function automatic logic [1:0] popcount2(input logic [1:0] v);
      return {1'b0, v[0]} + {1'b0, v[1]};
   endfunction

endpackage

// File: rtl/fq_storage.sv
// Circular entry store for the fetch queue: two write ports at tail/tail+1,
// two asynchronous read ports at head/head+1. Contents are never reset.
module fq_storage
   import fetch_queue_pkg::*;
#(
   parameter int DEPTH = 8,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic            clk,
   input  logic [1:0]      we_i,
   input  logic [AW-1:0]   waddr0_i,
   input  logic [AW-1:0]   waddr1_i,
   input  fq_entry_t       wdata0_i,
   input  fq_entry_t       wdata1_i,
   input  logic [AW-1:0]   raddr0_i,
   input  logic [AW-1:0]   raddr1_i,
   output fq_entry_t       rdata0_o,
   output fq_entry_t       rdata1_o
);

   fq_entry_t mem_q [DEPTH];

   // The two write addresses are always consecutive, so they never collide.
   always_ff @(posedge clk) begin
      if (we_i[0]) mem_q[waddr0_i] <= wdata0_i;
      if (we_i[1]) mem_q[waddr1_i] <= wdata1_i;
   end

   assign rdata0_o = mem_q[raddr0_i];
   assign rdata1_o = mem_q[raddr1_i];

endmodule

// File: rtl/fetch_queue.sv
// Dual-issue instruction fetch queue with stall/flush handling.
// Optional same-cycle push-to-issue bypass when empty: FETCH_QUEUE_BYPASS_EN.
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int XLEN  = FQ_XLEN
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [1:0]            push_valid_i,
   input  logic [2*XLEN-1:0]     push_instr_i,
   input  logic [2*XLEN-1:0]     push_pc_i,
   output logic                  push_ready_o,
   input  logic                  stall_i,
   input  logic                  flush_i,
   output logic [1:0]            issue_valid_o,
   output logic [2*XLEN-1:0]     issue_instr_o,
   output logic [2*XLEN-1:0]     issue_pc_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0] head_q, head_d;
   logic [AW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;

   logic [1:0]    push_v;
   logic          push_acc;
   logic          bypass;
   logic [1:0]    stor_valid;
   logic [1:0]    wr_en;
   logic [1:0]    n_push;
   logic [1:0]    n_pop;

   fq_entry_t     wr_entry    [2];
   fq_entry_t     rd_entry    [2];
   fq_entry_t     issue_entry [2];

   // Slot1 without slot0 is not a legal fetch group; treat it as empty.
   assign push_v       = (push_valid_i == 2'b10) ? 2'b00 : push_valid_i;
   assign push_ready_o = (count_q <= CW'(DEPTH - 2));
   assign push_acc     = push_ready_o && !flush_i && (push_v != 2'b00);
   assign stor_valid   = (count_q == '0)     ? 2'b00 :
                         (count_q == CW'(1)) ? 2'b01 : 2'b11;

`ifdef FETCH_QUEUE_BYPASS_EN
   assign bypass = (count_q == '0) && !stall_i && push_acc;
`else
   assign bypass = 1'b0;
`endif

   assign issue_valid_o = bypass ? push_v : stor_valid;
   assign wr_en         = (push_acc && !bypass) ? push_v : 2'b00;
   assign n_push        = popcount2(wr_en);
   assign n_pop         = (!stall_i && !flush_i && !bypass) ? popcount2(stor_valid) : 2'b00;
   assign count_o       = count_q;

   always_comb begin
      head_d  = head_q + AW'(n_pop);
      tail_d  = tail_q + AW'(n_push);
      count_d = count_q + CW'(n_push) - CW'(n_pop);
      if (flush_i) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   fq_storage #(
      .DEPTH (DEPTH)
   ) u_storage (
      .clk      (clk),
      .we_i     (wr_en),
      .waddr0_i (tail_q),
      .waddr1_i (tail_q + AW'(1)),
      .wdata0_i (wr_entry[0]),
      .wdata1_i (wr_entry[1]),
      .raddr0_i (head_q),
      .raddr1_i (head_q + AW'(1)),
      .rdata0_o (rd_entry[0]),
      .rdata1_o (rd_entry[1])
   );

   // Lane 0 is the older slot/entry; invalid lanes present a NOP bubble with PC 0.
   for (genvar gi = 0; gi < 2; gi++) begin : g_lane
      assign wr_entry[gi].pc    = push_pc_i[gi*XLEN +: XLEN];
      assign wr_entry[gi].instr = push_instr_i[gi*XLEN +: XLEN];
      assign issue_entry[gi]    = bypass ? wr_entry[gi] : rd_entry[gi];
      assign issue_instr_o[gi*XLEN +: XLEN] =
         issue_valid_o[gi] ? issue_entry[gi].instr : NOP_INSTR;
      assign issue_pc_o[gi*XLEN +: XLEN] =
         issue_valid_o[gi] ? issue_entry[gi].pc : '0;
   end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Dual-issue instruction fetch queue between instruction memory and the two decode lanes. Buffers up to DEPTH fetched instructions with their PCs, accepts up to two per cycle from fetch, and presents the two oldest entries in program order to decode lanes 1 and 2. Decode-stage stall and flush requests from the hazard logic are applied here: a stall holds the head, a flush empties the queue on a taken jump/branch.

## Interface
- DEPTH, 8: entry count; power of two, ≥4
- XLEN, 32: instruction and PC width
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- push_valid_i  in  2  bit0 = slot0 present, bit1 = slot1 present; 2'b10 treated as 2'b00
- push_instr_i  in  2×XLEN  slot0 = older instruction
- push_pc_i  in  2×XLEN  PCs matching push_instr_i
- push_ready_o  out  1  high when free entries ≥ 2
- stall_i  in  1  OR of decode stalls; no entries leave
- flush_i  in  1  OR of decode flushes; discard all contents
- issue_valid_o  out  2  bit0 → lane 1, bit1 → lane 2; bit1 implies bit0
- issue_instr_o  out  2×XLEN  oldest two entries; NOP when not valid
- issue_pc_o  out  2×XLEN  PCs of issued entries; 0 when not valid
- count_o  out  $clog2(DEPTH)+1  registered occupancy

## Operation
- Storage: circular buffer, head/tail pointers $clog2(DEPTH) bits, wrap modulo DEPTH; occupancy counter kept separately (full/empty not derived from pointers).
- Push accepted iff push_ready_o && !flush_i; writes 1 or 2 entries at tail, slot0 first; tail advances by popcount(push_valid_i).
- Issue: issue_valid_o = 2'b00 if count=0, 2'b01 if count=1, 2'b11 if count≥2; entries head, head+1.
- Pop: if !stall_i && !flush_i, head advances by popcount(issue_valid_o). In-order only: lane 2 never issues without lane 1.
- Same-cycle push and pop allowed; count_next = count + pushed − popped.
- push_ready_o from registered count only (ignores same-cycle pop); never overflows.
- Invalid issue slots drive NOP 32'h00000013 and PC 0, so decode sees a bubble.
- flush_i: head, tail, count ← 0 next cycle; same-cycle push dropped; overrides stall_i.
- stall_i with count=0: no effect beyond blocking bypass (see Configuration).
- Reset identical to flush; storage contents not cleared.

## Timing
- Reset values: issue_valid_o 0, issue_instr_o NOP, issue_pc_o 0, count_o 0, push_ready_o 1 (first cycle after rst low).
- Push-to-issue latency: 1 cycle (0 with bypass).
- Throughput: 2 in, 2 out per cycle sustained.
- Flush at cycle N: issue_valid_o = 0 at N+1; first post-flush push at N+1 visible at N+2.
- Full (count=DEPTH): push_ready_o 0; issue continues; ready returns the cycle after count ≤ DEPTH−2.
- Pointer wrap DEPTH−1 → 0, including a two-entry write/read straddling the wrap.

## Configuration
- FETCH_QUEUE_BYPASS_EN defined: when count=0, !stall_i, !flush_i, and push accepted, push slots drive issue outputs combinationally the same cycle and are consumed without being written; count stays 0. If stalled, entries are written normally.
- Undefined: no push→issue combinational path; all entries pass through storage.

## Structure
- Package fetch_queue_pkg: NOP_INSTR = 32'h00000013; typedef fq_entry_t {pc, instr}; function popcount2.
- Sub-module fq_storage: DEPTH × fq_entry_t array, two write ports (tail, tail+1), two async read ports (head, head+1). Control (pointers, count, bypass mux) in fetch_queue.

## Test plan
- Reset, then push 2'b11 {PC 0x0,0x4} → next cycle issue_valid_o 2'b11, PCs 0x0/0x4, count_o 0 after pop.
- Push 5 pairs with stall_i held → count_o 8, push_ready_o 0 after 4 pairs; 5th pair dropped; release stall → 4 cycles of 2'b11 issue in PC order.
- Push 2'b01 single (PC 0x8) → issue_valid_o 2'b01, lane 2 instr 0x00000013, PC 0.
- Flush with count 6 and simultaneous push → next cycle count_o 0, issue_valid_o 0, pushed pair absent.
- Run 20 cycles of mixed 1/2 pushes and pops across pointer wrap → issued PCs strictly sequential, no loss/duplication.
- With FETCH_QUEUE_BYPASS_EN, empty queue, push PC 0x40 → issue_valid_o 2'b11 same cycle; with stall_i high → issued next cycle after release.
